// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: tracks in-flight writers per stage and raises stall/forwarding selects.
// Optional macro FORWARDING_EN enables youngest-stage forwarding with load-use stalls only.
module hazard_scoreboard #(
  parameter int NREGS = 16,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16,
  localparam int REG_W  = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int FSEL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wb_en,
  input  logic [REG_W-1:0]  issue_dest,
  input  logic              issue_is_load,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic              src1_en,
  input  logic              src2_en,
  input  logic              flush,
  output logic              hazard,
  output logic [FSEL_W-1:0] fwd_sel1,
  output logic [FSEL_W-1:0] fwd_sel2,
  output logic [CNT_W-1:0]  stall_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DEPTH-1:0] sb_vld;
  logic [DEPTH-1:0] sb_load;
  logic [REG_W-1:0] sb_dest [DEPTH];
  logic [DEPTH-1:0] m1, m2;
  logic             raw;
  logic             load_en;

  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      m1[k] = src1_en && sb_vld[k] && (sb_dest[k] == src1);
      m2[k] = src2_en && sb_vld[k] && (sb_dest[k] == src2);
    end
  end

`ifdef FORWARDING_EN
  // Only a load still in EXE cannot be forwarded in time.
  assign raw = (m1[0] | m2[0]) & sb_load[0];

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (m1[k]) fwd_sel1 = FSEL_W'(k + 1);
      if (m2[k]) fwd_sel2 = FSEL_W'(k + 1);
    end
  end
`else
  logic unused_load;
  assign unused_load = ^sb_load;
  assign raw         = |(m1 | m2);
  assign fwd_sel1    = '0;
  assign fwd_sel2    = '0;
`endif

  assign hazard  = issue_valid && !flush && raw;
  assign load_en = issue_valid && issue_wb_en && !hazard && !flush;

  // Stage 0 takes the issuing writer or a bubble; later stages always shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_vld    <= '0;
      sb_load   <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) sb_dest[k] <= '0;
    end else begin
      sb_vld[0]  <= load_en;
      sb_load[0] <= load_en && issue_is_load;
      sb_dest[0] <= load_en ? issue_dest : '0;
      for (int k = 1; k < DEPTH; k++) begin
        sb_vld[k]  <= sb_vld[k-1];
        sb_load[k] <= sb_load[k-1];
        sb_dest[k] <= sb_dest[k-1];
      end
      if (hazard) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (DEPTH=3); expectations adapt to FORWARDING_EN.
module tb_hazard_scoreboard;
  localparam int REG_W  = 4;
  localparam int FSEL_W = 2;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk, rst;
  logic issue_valid, issue_wb_en, issue_is_load, flush;
  logic [REG_W-1:0] issue_dest, src1, src2;
  logic src1_en, src2_en;
  logic hazard, hazard_s;
  logic [FSEL_W-1:0] fwd_sel1, fwd_sel2, fwd1_s, fwd2_s;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_s;

  hazard_scoreboard #(.NREGS(16), .DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src1(src1), .src2(src2),
    .src1_en(src1_en), .src2_en(src2_en), .flush(flush), .hazard(hazard),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt));

  hazard_scoreboard #(.NREGS(16), .DEPTH(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
    .issue_dest(issue_dest), .issue_is_load(issue_is_load), .src1(src1), .src2(src2),
    .src1_en(src1_en), .src2_en(src2_en), .flush(flush), .hazard(hazard_s),
    .fwd_sel1(fwd1_s), .fwd_sel2(fwd2_s), .stall_cnt(stall_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic              hz;
    logic [FSEL_W-1:0] f1;
    logic [FSEL_W-1:0] f2;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int unsigned cnt_m = 0;
  int unsigned cnt_s = 0;

  function automatic logic hz(input logic no_fwd, input logic with_fwd);
    return FWD ? with_fwd : no_fwd;
  endfunction

  function automatic logic [FSEL_W-1:0] fs(input logic [FSEL_W-1:0] v);
    return FWD ? v : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic iv, input logic wb, input logic [3:0] dest,
                      input logic ld, input logic s1e, input logic [3:0] s1, input logic s2e,
                      input logic [3:0] s2, input logic fl, input logic ehz,
                      input logic [FSEL_W-1:0] ef1, input logic [FSEL_W-1:0] ef2);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    issue_valid = iv; issue_wb_en = wb; issue_dest = dest; issue_is_load = ld;
    src1_en = s1e; src1 = s1; src2_en = s2e; src2 = s2; flush = fl;
    e.tag = tag; e.hz = ehz; e.f1 = ef1; e.f2 = ef2;
    q.push_back(e);
    #1;
    e = q.pop_front();
    chk({e.tag, ".hazard"}, 32'(hazard), 32'(e.hz));
    chk({e.tag, ".fwd_sel1"}, 32'(fwd_sel1), 32'(e.f1));
    chk({e.tag, ".fwd_sel2"}, 32'(fwd_sel2), 32'(e.f2));
    chk({e.tag, ".hazard_sat"}, 32'(hazard_s), 32'(e.hz));
    chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), cnt_m);
    chk({e.tag, ".stall_cnt_sat"}, 32'(stall_s), cnt_s);
    if (e.hz) begin
      if (cnt_m < 32'd65535) cnt_m++;
      if (cnt_s < 32'd3) cnt_s++;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input logic iv, input logic wb, input logic [3:0] dest);
    @(negedge clk);
    rst = 1'b1;
    issue_valid = iv; issue_wb_en = wb; issue_dest = dest; issue_is_load = 1'b0;
    src1_en = 1'b0; src2_en = 1'b0; flush = 1'b0;
    @(posedge clk);
    cnt_m = 0;
    cnt_s = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; issue_valid = 0; issue_wb_en = 0; issue_dest = 0; issue_is_load = 0;
    src1 = 0; src2 = 0; src1_en = 0; src2_en = 0; flush = 0;
    do_reset(0, 0, 0);
    do_reset(0, 0, 0);
    idle("rst_idle");

    // RAW on R2 from a non-load writer
    step("r2_issue", 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r2_use0",  1, 0, 0, 0, 1, 2, 0, 0, 0, hz(1, 0), fs(1), 0);
    step("r2_use1",  1, 0, 0, 0, 1, 2, 0, 0, 0, hz(1, 0), fs(2), 0);
    step("r2_use2",  1, 0, 0, 0, 1, 2, 0, 0, 0, hz(1, 0), fs(3), 0);
    step("r2_clear", 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);

    // RAW on R5 through src2
    step("r5_issue", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r5_use0",  1, 0, 0, 0, 0, 0, 1, 5, 0, hz(1, 0), 0, fs(1));
    step("r5_use1",  1, 0, 0, 0, 0, 0, 1, 5, 0, hz(1, 0), 0, fs(2));
    idle("drain_a");

    // Load-use on R7
    step("r7_issue", 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r7_use0",  1, 0, 0, 0, 1, 7, 0, 0, 0, 1, fs(1), 0);
    step("r7_use1",  1, 0, 0, 0, 1, 7, 0, 0, 0, hz(1, 0), fs(2), 0);
    idle("drain_b");
    idle("drain_c");

    // No stall without a valid issue
    step("r6_issue", 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r6_noiv",  0, 0, 0, 0, 1, 6, 0, 0, 0, 0, fs(1), 0);
    idle("drain_d");

    // Flushed issue becomes a bubble
    step("r3_flush", 1, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("r3_use",   1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);

    // Flush overrides a hazard in the same cycle
    step("r8_issue", 1, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r8_flush", 1, 0, 0, 0, 1, 8, 0, 0, 1, 0, fs(1), 0);
    step("r8_use",   1, 0, 0, 0, 1, 8, 0, 0, 0, hz(1, 0), fs(2), 0);
    idle("drain_e");
    idle("drain_f");

    // Youngest of two R4 writers wins; register 0 style tracking via R4 both sources
    step("r4_issue_a", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r4_issue_b", 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r4_use",     1, 0, 0, 0, 1, 4, 1, 4, 0, hz(1, 0), fs(1), fs(1));

    // Reset with entries occupied and an issue pending
    do_reset(1, 1, 4);
    step("post_rst", 1, 0, 0, 0, 1, 4, 1, 4, 0, 0, 0, 0);

    // Register 0 is tracked like any other
    step("r0_issue", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("r0_use",   1, 0, 0, 0, 1, 0, 0, 0, 0, hz(1, 0), fs(1), 0);
    idle("drain_g");
    idle("drain_h");

    // Repeated load-use stalls drive the 2-bit counter into saturation
    for (int i = 0; i < 5; i++) begin
      step("sat_ld",  1, 1, 4'(10 + i), 1, 0, 0, 0, 0, 0, 0, 0, 0);
      step("sat_use", 1, 0, 0, 0, 1, 4'(10 + i), 0, 0, 0, 1, fs(1), 0);
      idle("sat_d0");
      idle("sat_d1");
      idle("sat_d2");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
